// File: rtl/ball_motion.sv
// ball_motion -- serve/park/move controller for a square ball on a raster
// display, plus per-pixel "inside the ball" flags for the video mixer.
//
// The ball sits at the screen centre while PARKED. A serve request arms a
// frame counter. After SERVE_DELAY frame ticks the ball starts MOVING by STEP
// pixels per frame on each axis. Position is clamped to the visible area, so
// it never wraps.
//
// Optional feature (macro BALL_MOTION_MISS_EN): a left-moving update that
// lands X on 0 pulses o_Miss for one cycle. The ball is then parked and
// recentred on the following cycle. Without the macro, X simply clamps at 0,
// the ball keeps moving and o_Miss is tied low.
//
// Ports:
//   i_Clk          pixel clock
//   i_Reset        synchronous active-high reset
//   i_HCount/VCount current raster column/row
//   i_Frame_Tick   one-cycle pulse at the start of vertical blank
//   i_HDir/i_VDir  direction (HDir 1 = left, VDir 1 = up); sampled on ticks
//   i_Serve        serve request (only honoured while PARKED)
//   o_HBall/o_VBall raster inside ball column/row span (1-cycle latency)
//   o_Ball         o_HBall & o_VBall, same alignment
//   o_XPos/o_YPos  ball top-left corner
//   o_Moving       high while in MOVING
//   o_Miss         one-cycle miss pulse (BALL_MOTION_MISS_EN only)
module ball_motion #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int STEP        = 2,
  parameter int SERVE_DELAY = 30
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [9:0] i_HCount,
  input  logic [9:0] i_VCount,
  input  logic       i_Frame_Tick,
  input  logic       i_HDir,
  input  logic       i_VDir,
  input  logic       i_Serve,
  output logic       o_HBall,
  output logic       o_VBall,
  output logic       o_Ball,
  output logic [9:0] o_XPos,
  output logic [9:0] o_YPos,
  output logic       o_Moving,
  output logic       o_Miss
);

  localparam int          XMAX    = H_ACTIVE - BALL_SIZE;
  localparam int          YMAX    = V_ACTIVE - BALL_SIZE;
  localparam logic [9:0]  X_CTR   = 10'(XMAX / 2);
  localparam logic [9:0]  Y_CTR   = 10'(YMAX / 2);
  localparam logic [10:0] XMAX_W  = 11'(XMAX);
  localparam logic [10:0] YMAX_W  = 11'(YMAX);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] SIZE_W  = 11'(BALL_SIZE);
  localparam int          CNT_W   = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY);

  typedef enum logic [1:0] {
    PARKED = 2'd0,
    ARMED  = 2'd1,
    MOVING = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [9:0]       x_r, y_r, x_s, y_s;
  logic             h_in_s, v_in_s;
  logic             h_ball_r, v_ball_r, ball_r, moving_r;
`ifdef BALL_MOTION_MISS_EN
  logic             miss_s, miss_r;
`endif

  // One axis step in 11 bits; decrementing saturates at 0, incrementing at lim.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                           input logic [10:0] lim);
    logic [10:0] wide;
    logic [10:0] res;
    wide = {1'b0, pos};
    if (dec) begin
      if (wide < STEP_W) res = 11'd0;
      else               res = wide - STEP_W;
    end else begin
      if ((wide + STEP_W) > lim) res = lim;
      else                       res = wide + STEP_W;
    end
    return res[9:0];
  endfunction

  // Raster-inside-ball terms, evaluated against the current ball position.
  always_comb begin
    h_in_s = ({1'b0, i_HCount} >= {1'b0, x_r}) &&
             ({1'b0, i_HCount} <  ({1'b0, x_r} + SIZE_W));
    v_in_s = ({1'b0, i_VCount} >= {1'b0, y_r}) &&
             ({1'b0, i_VCount} <  ({1'b0, y_r} + SIZE_W));
  end

  // Next state, frame counter and position.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    cnt_inc_s = cnt_r + CNT_W'(1);
    x_s       = x_r;
    y_s       = y_r;
`ifdef BALL_MOTION_MISS_EN
    miss_s    = 1'b0;
`endif
    case (state_r)
      PARKED: begin
        x_s = X_CTR;
        y_s = Y_CTR;
        // A tick coinciding with the serve is deliberately not counted.
        if (i_Serve) begin
          state_s = ARMED;
          cnt_s   = '0;
        end else begin
          state_s = PARKED;
        end
      end
      ARMED: begin
        if (i_Frame_Tick) begin
          cnt_s = cnt_inc_s;
          // The arming tick itself does not move the ball.
          if (cnt_inc_s == CNT_LAST) state_s = MOVING;
          else                       state_s = ARMED;
        end else begin
          state_s = ARMED;
        end
      end
      MOVING: begin
        state_s = MOVING;
`ifdef BALL_MOTION_MISS_EN
        // The cycle after a miss pulse parks and recentres the ball.
        if (miss_r) begin
          state_s = PARKED;
          x_s     = X_CTR;
          y_s     = Y_CTR;
        end else if (i_Frame_Tick) begin
          x_s    = step_axis(x_r, i_HDir, XMAX_W);
          y_s    = step_axis(y_r, i_VDir, YMAX_W);
          miss_s = i_HDir && ({1'b0, x_r} <= STEP_W);
        end else begin
          x_s = x_r;
          y_s = y_r;
        end
`else
        if (i_Frame_Tick) begin
          x_s = step_axis(x_r, i_HDir, XMAX_W);
          y_s = step_axis(y_r, i_VDir, YMAX_W);
        end else begin
          x_s = x_r;
          y_s = y_r;
        end
`endif
      end
      default: begin
        state_s = PARKED;
        cnt_s   = '0;
        x_s     = X_CTR;
        y_s     = Y_CTR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state_r <= PARKED;
    else         state_r <= state_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_r    <= '0;
      x_r      <= X_CTR;
      y_r      <= Y_CTR;
      h_ball_r <= 1'b0;
      v_ball_r <= 1'b0;
      ball_r   <= 1'b0;
      moving_r <= 1'b0;
`ifdef BALL_MOTION_MISS_EN
      miss_r   <= 1'b0;
`endif
    end else begin
      cnt_r    <= cnt_s;
      x_r      <= x_s;
      y_r      <= y_s;
      h_ball_r <= h_in_s;
      v_ball_r <= v_in_s;
      ball_r   <= h_in_s && v_in_s;
      // Decoded from next state so o_Moving lines up with the state register.
      moving_r <= (state_s == MOVING);
`ifdef BALL_MOTION_MISS_EN
      miss_r   <= miss_s;
`endif
    end
  end

  assign o_HBall  = h_ball_r;
  assign o_VBall  = v_ball_r;
  assign o_Ball   = ball_r;
  assign o_XPos   = x_r;
  assign o_YPos   = y_r;
  assign o_Moving = moving_r;
`ifdef BALL_MOTION_MISS_EN
  assign o_Miss   = miss_r;
`else
  assign o_Miss   = 1'b0;
`endif

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;

  logic       clk;
  logic       rst;
  logic [9:0] hc, vc;
  logic       tk, hd, vd, srv;
  logic       o_HBall, o_VBall, o_Ball, o_Moving, o_Miss;
  logic [9:0] o_XPos, o_YPos;

  ball_motion dut (
    .i_Clk(clk), .i_Reset(rst), .i_HCount(hc), .i_VCount(vc),
    .i_Frame_Tick(tk), .i_HDir(hd), .i_VDir(vd), .i_Serve(srv),
    .o_HBall(o_HBall), .o_VBall(o_VBall), .o_Ball(o_Ball),
    .o_XPos(o_XPos), .o_YPos(o_YPos), .o_Moving(o_Moving), .o_Miss(o_Miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_X = 0, S_Y = 1, S_HB = 2, S_VB = 3, S_B = 4, S_MOV = 5, S_MISS = 6;

  typedef struct {
    int          due;
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_X:     return {22'd0, o_XPos};
      S_Y:     return {22'd0, o_YPos};
      S_HB:    return {31'd0, o_HBall};
      S_VB:    return {31'd0, o_VBall};
      S_B:     return {31'd0, o_Ball};
      S_MOV:   return {31'd0, o_Moving};
      S_MISS:  return {31'd0, o_Miss};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: compares every expectation that falls due on this sample edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e  = sb.pop_front();
      checks = checks + 1;
      if (mon_e.due < cyc) begin
        errors = errors + 1;
        $display("FAIL %s: not sampled (due cycle %0d, now %0d)", mon_e.name, mon_e.due, cyc);
      end else if (actual(mon_e.sel) !== mon_e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                 mon_e.name, actual(mon_e.sel), mon_e.exp, cyc);
      end
    end
  end

  // Apply one cycle of inputs, away from the active edge.
  task automatic drive(input logic r, input logic s, input logic t, input logic h,
                       input logic v, input logic [9:0] hcnt, input logic [9:0] vcnt);
    @(negedge clk);
    rst = r; srv = s; tk = t; hd = h; vd = v; hc = hcnt; vc = vcnt;
  endtask

  // Expected response to the inputs just driven, seen one cycle later.
  task automatic expect1(input string n, input int sel, input int val);
    exp_t e;
    e.due  = cyc + 1;
    e.name = n;
    e.sel  = sel;
    e.exp  = 32'(val);
    sb.push_back(e);
  endtask

  int ex, ey;

  initial begin
    rst = 1'b1; srv = 1'b0; tk = 1'b0; hd = 1'b0; vd = 1'b0; hc = 10'd0; vc = 10'd0;

    // Reset with the raster inside the ball: outputs must still be 0.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd316, 10'd236);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd316, 10'd236);
    expect1("rst_x", S_X, 316);   expect1("rst_y", S_Y, 236);
    expect1("rst_ball", S_B, 0);  expect1("rst_hball", S_HB, 0);
    expect1("rst_mov", S_MOV, 0); expect1("rst_miss", S_MISS, 0);

    // Ball span at the centre position.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd316, 10'd236);
    expect1("span_ball", S_B, 1); expect1("span_hb", S_HB, 1); expect1("span_vb", S_VB, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd324, 10'd236);
    expect1("hend_hb", S_HB, 0); expect1("hend_vb", S_VB, 1); expect1("hend_ball", S_B, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd323, 10'd243);
    expect1("corner_ball", S_B, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd323, 10'd244);
    expect1("vend_vb", S_VB, 0); expect1("vend_ball", S_B, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd315, 10'd236);
    expect1("hbeg_hb", S_HB, 0);

    // Serve, then 30 ticks; a serve in ARMED must not restart the count.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    expect1("serve_mov", S_MOV, 0);
    for (int i = 1; i <= 29; i++) begin
      drive(1'b0, (i == 15), 1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      expect1("armed_mov", S_MOV, 0);
      expect1("armed_x", S_X, 316);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
    expect1("tick30_mov", S_MOV, 1); expect1("tick30_x", S_X, 316); expect1("tick30_y", S_Y, 236);

    // No tick: direction changes alone must not move the ball.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    expect1("notick_x", S_X, 316); expect1("notick_y", S_Y, 236);

    // Tick 31: right and up.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0);
    expect1("tick31_x", S_X, 318); expect1("tick31_y", S_Y, 234);

    // Serve while moving is ignored.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    expect1("srvmov_mov", S_MOV, 1); expect1("srvmov_x", S_X, 318);

    // Left and down until Y clamps at 472 and X reaches 0.
    ex = 318; ey = 234;
    for (int k = 1; k <= 159; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      ex = (ex <= 2) ? 0 : ex - 2;
      ey = (ey + 2 > 472) ? 472 : ey + 2;
      expect1("walk_x", S_X, ex);
      expect1("walk_y", S_Y, ey);
      expect1("walk_mov", S_MOV, 1);
`ifdef BALL_MOTION_MISS_EN
      expect1("walk_miss", S_MISS, (k == 159) ? 1 : 0);
`else
      expect1("walk_miss", S_MISS, 0);
`endif
    end
`ifdef BALL_MOTION_MISS_EN
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
    expect1("miss_park_mov", S_MOV, 0); expect1("miss_park_x", S_X, 316);
    expect1("miss_park_y", S_Y, 236);   expect1("miss_clear", S_MISS, 0);
`else
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    expect1("clamp0_x", S_X, 0); expect1("clamp0_mov", S_MOV, 1);
    expect1("clamp_ymax", S_Y, 472); expect1("clamp0_miss", S_MISS, 0);
`endif

    // Reset, then reset mid-ARMED.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    expect1("rst2_mov", S_MOV, 0); expect1("rst2_x", S_X, 316);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    expect1("rst_armed_mov", S_MOV, 0);

    // Serve coinciding with a tick: 30 further ticks still required.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    expect1("srvtick_mov", S_MOV, 0);
    for (int i = 1; i <= 29; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
      expect1("srvtick_armed_mov", S_MOV, 0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    expect1("srvtick_30_mov", S_MOV, 1);

    // Walk up-left to X=100, then reset while moving.
    ex = 316; ey = 236;
    for (int k = 1; k <= 108; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      ex = ex - 2; ey = ey - 2;
    end
    expect1("x100_x", S_X, ex); expect1("x100_y", S_Y, ey);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
    expect1("rstmov_mov", S_MOV, 0); expect1("rstmov_x", S_X, 316); expect1("rstmov_y", S_Y, 236);

    // Let the monitor drain.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
